rv_decode_stage: RTL
====================

// Module: rv_decode_stage
// PURPOSE
//  Registered RV32I/RV64I instruction decode stage, optional M extension. Sits between fetch and execute.
//  Decodes inst into control bundle + trap flags and holds them in one pipeline register.
//  Uses valid/ready handshake and supports flush; carries pc alongside the decoded fields.
// PARAMETERS
//  XLEN      32  datapath width; 32 or 64. 64 adds LD/LWU/SD, OP-IMM-32/OP-32 and 6-bit shamt.
//  ENABLE_M  0   1 decodes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU (+W forms when XLEN=64).
//  PC_W      XLEN  width of pc passthrough.
// PORTS
//  clk               in   1     clock
//  rst_n             in   1     asynchronous active-low reset
//  flush             in   1     kill held entry and any accepted-this-cycle entry
//  in_valid          in   1     fetch offers inst/pc
//  in_ready          out  1     stage can accept
//  in_inst           in   32    instruction word
//  in_pc             in   PC_W  pc of in_inst
//  out_valid         out  1     decoded entry held
//  out_ready         in   1     execute consumes entry
//  out_pc            out  PC_W  registered pc
//  out_alu_func      out  5     alu_func_e (pkg)
//  out_csr_func      out  2     0 RW, 1 RS, 2 RC
//  out_mem_len       out  2     0 B, 1 H, 2 W, 3 D
//  out_ctrl          out  12    {ctrl_imm,L,B,J,w_csr,wmem,wb,mem_sign,ctrl_branch_addr,ctrl_src1,op32,muldiv}
//  out_trap          out  4     {illegal_instr,ecall,ebreak,mret}
// BEHAVIOUR
//  - Reset: out_valid=0, and all out_* data = 0. in_ready = 1 after reset.
//  - in_ready = !out_valid | out_ready. This is combinational from out_ready, with no bubble on steady flow.
//  - Accept when in_valid&in_ready&!flush. Decoded result is registered, so out_valid rises next cycle (1-cycle latency).
//  - out_valid&out_ready&!accept -> out_valid=0 next cycle. Accept and drain in the same cycle -> new entry replaces old.
//  - out_valid&!out_ready -> all out_* held stable. Data only changes when an entry is loaded.
//  - flush: out_valid=0 next cycle regardless of in_valid/out_ready. Input offered in that cycle is dropped. in_ready is unaffected.
//  - Trapping instruction: it is still passed as a valid entry. illegal_instr=1 forces wb=wmem=w_csr=L=B=J=0.
//  - ALU codes keep the legacy 4-bit set as {1'b0,code}:
//    - ADD0, SUB1, XOR2, OR3, AND4, SLTU/BLTU5, SLT/BLT6, SLL7, SRL8, SRA9, BEQ10, BNE11, BGEU12, BGE13, LINK14, LUI15.
//    - M ops use {2'b10,funct3}.
//  - op32=1 for OP-IMM-32/OP-32 (XLEN=64 only). Execute truncates to 32 and sign-extends.
//  - Legal only if all of the following hold:
//    - branches: funct3 is not 01x.
//    - loads: funct3 is in {000,001,010,100,101}; with XLEN=64, 011 (LD) and 110 (LWU) are also legal.
//    - stores: funct3 <= 010; with XLEN=64, 011 (SD) is also legal.
//    - OP: funct7 = 0; or 0100000 with funct3 in {000,101}; or 0000001 when ENABLE_M.
//    - SLLI/SRLI/SRAI: funct7[0] is legal only when XLEN=64. This is stricter than the old RV32 decoder.
//    - OP-32: funct3 is in {000,001,101}. With ENABLE_M, funct7=0000001 and funct3 in {000,100,101,110,111}.
//    - OP-IMM-32: funct3 is in {000,001,101}, and the shamt field must be 5 bits.
//    - SYSTEM funct3 in {000,100}: legal only for ECALL/EBREAK/MRET.
//    - JALR: funct3 must be 000 (new check).
//    - Any other opcode is illegal.
//  - Reset asserted mid-transfer: entry lost, out_valid=0 immediately (async). Fetch must replay.
// STRUCTURE
//  - Package rv_decode_pkg holds:
//    - alu_func_e, csr_func_e, mem_len_e enums.
//    - ctrl_t packed struct (field order as out_ctrl).
//    - opcode localparams (OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM, OP_IMM32, OP, OP32, LUI, AUIPC, JAL, JALR, SYSTEM).
//  - Sub-module rv_decoder: purely combinational, (inst) -> ctrl_t, alu, csr, mem_len, trap. Takes the same XLEN and ENABLE_M parameters.
//  - This module holds the handshake and the pipeline register only.
// TESTING
//  - Reset, then XLEN=32 ADD 0x00B50533, valid 1 cycle:
//    - next cycle out_valid=1, alu=0, wb=1, ctrl_imm=0, trap=0.
//  - SUB 0x40B50533 -> alu=1. SRAI 0x4025D513 -> alu=9, ctrl_imm=1.
//    - SLLI 0x02059513: XLEN=32 -> illegal=1, wb=0. XLEN=64 -> legal, alu=7.
//  - LD 0x0005B503: XLEN=64 -> L=1, mem_len=3, mem_sign=1. XLEN=32 -> illegal=1.
//  - MUL 0x02B50533: ENABLE_M=1 -> alu=5'b10000, muldiv=1. ENABLE_M=0 -> illegal=1.
//  - Backpressure: two back-to-back ADDs, out_ready=0 for 3 cycles:
//    - first entry stable, in_ready=0.
//    - out_ready=1 -> second entry appears the next cycle, no loss or duplication.
//  - Mixed events:
//    - flush with in_valid=1 and out_valid=1 -> out_valid=0 next cycle, offered inst dropped.
//    - rst_n low mid-stream -> out_valid=0 without a clock edge.
//    - ECALL 0x00000073 -> trap=0100. MRET -> 0001.

Source files
------------

// File: rtl/rv_decode_pkg.sv
// Shared types for the RV32I/RV64I decode stage: ALU/CSR/memory-length codes,
// the packed control bundle and the base opcode map.
package rv_decode_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_XOR    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_AND    = 5'd4,
    ALU_SLTU   = 5'd5,
    ALU_SLT    = 5'd6,
    ALU_SLL    = 5'd7,
    ALU_SRL    = 5'd8,
    ALU_SRA    = 5'd9,
    ALU_BEQ    = 5'd10,
    ALU_BNE    = 5'd11,
    ALU_BGEU   = 5'd12,
    ALU_BGE    = 5'd13,
    ALU_LINK   = 5'd14,
    ALU_LUI    = 5'd15,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23
  } alu_func_e;

  typedef enum logic [1:0] {
    CSR_RW = 2'd0,
    CSR_RS = 2'd1,
    CSR_RC = 2'd2
  } csr_func_e;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_len_e;

  // Bit order matches out_ctrl: imm is bit 11, muldiv is bit 0.
  typedef struct packed {
    logic imm;
    logic load;
    logic branch;
    logic jump;
    logic w_csr;
    logic wmem;
    logic wb;
    logic mem_sign;
    logic branch_addr;
    logic src1;
    logic op32;
    logic muldiv;
  } ctrl_t;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_IMM32  = 7'h1B;
  localparam logic [6:0] OP        = 7'h33;
  localparam logic [6:0] OP32      = 7'h3B;
  localparam logic [6:0] LUI       = 7'h37;
  localparam logic [6:0] AUIPC     = 7'h17;
  localparam logic [6:0] JAL       = 7'h6F;
  localparam logic [6:0] JALR      = 7'h67;
  localparam logic [6:0] SYSTEM    = 7'h73;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

endpackage

// File: rtl/rv_decode_stage_decoder.sv
// Purely combinational instruction decoder: one 32-bit word in, control bundle,
// ALU/CSR/memory-length codes and trap flags out. Illegal words yield an all-zero bundle.
module rv_decoder
  import rv_decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [31:0] inst,
  output ctrl_t       ctrl,
  output alu_func_e   alu_func,
  output csr_func_e   csr_func,
  output mem_len_e    mem_len,
  output logic [3:0]  trap
);

  localparam bit IS64 = (XLEN == 64);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  ctrl_t     c_s;
  alu_func_e alu_s;
  csr_func_e csr_s;
  mem_len_e  len_s;
  logic      illegal_s;
  logic      ecall_s;
  logic      ebreak_s;
  logic      mret_s;

  function automatic alu_func_e int_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  int_alu = alt ? ALU_SUB : ALU_ADD;
      3'b001:  int_alu = ALU_SLL;
      3'b010:  int_alu = ALU_SLT;
      3'b011:  int_alu = ALU_SLTU;
      3'b100:  int_alu = ALU_XOR;
      3'b101:  int_alu = alt ? ALU_SRA : ALU_SRL;
      3'b110:  int_alu = ALU_OR;
      default: int_alu = ALU_AND;
    endcase
  endfunction

  function automatic alu_func_e branch_alu(input logic [2:0] f3);
    case (f3)
      3'b001:  branch_alu = ALU_BNE;
      3'b100:  branch_alu = ALU_SLT;
      3'b101:  branch_alu = ALU_BGE;
      3'b110:  branch_alu = ALU_SLTU;
      3'b111:  branch_alu = ALU_BGEU;
      default: branch_alu = ALU_BEQ;
    endcase
  endfunction

  // funct7[0] is shamt[5]; only a 64-bit datapath may use it.
  function automatic logic shamt_ok(input logic [6:0] f7, input logic allow_sra);
    shamt_ok = ((f7[6:1] == 6'b000000) || (allow_sra && (f7[6:1] == 6'b010000)))
               && (!f7[0] || IS64);
  endfunction

  // Raw field decode by opcode, legality evaluated alongside.
  always_comb begin
    c_s       = '0;
    alu_s     = ALU_ADD;
    csr_s     = CSR_RW;
    len_s     = MEM_B;
    illegal_s = 1'b0;
    ecall_s   = 1'b0;
    ebreak_s  = 1'b0;
    mret_s    = 1'b0;
    case (opcode)
      LUI: begin
        c_s.imm = 1'b1; c_s.wb = 1'b1; alu_s = ALU_LUI;
      end
      AUIPC: begin
        c_s.imm = 1'b1; c_s.wb = 1'b1; c_s.src1 = 1'b1;
      end
      JAL: begin
        c_s.imm = 1'b1; c_s.jump = 1'b1; c_s.wb = 1'b1;
        c_s.branch_addr = 1'b1; c_s.src1 = 1'b1; alu_s = ALU_LINK;
      end
      JALR: begin
        c_s.imm = 1'b1; c_s.jump = 1'b1; c_s.wb = 1'b1; c_s.src1 = 1'b1;
        alu_s = ALU_LINK;
        illegal_s = (funct3 != 3'b000);
      end
      OP_BRANCH: begin
        c_s.branch = 1'b1; c_s.branch_addr = 1'b1;
        alu_s = branch_alu(funct3);
        illegal_s = (funct3[2:1] == 2'b01);
      end
      OP_LOAD: begin
        c_s.imm = 1'b1; c_s.load = 1'b1; c_s.wb = 1'b1;
        c_s.mem_sign = !funct3[2];
        len_s = mem_len_e'(funct3[1:0]);
        case (funct3)
          3'b011, 3'b110: illegal_s = !IS64;
          3'b111:         illegal_s = 1'b1;
          default:        illegal_s = 1'b0;
        endcase
      end
      OP_STORE: begin
        c_s.imm = 1'b1; c_s.wmem = 1'b1;
        len_s = mem_len_e'(funct3[1:0]);
        illegal_s = !((funct3 <= 3'b010) || (IS64 && (funct3 == 3'b011)));
      end
      OP_IMM: begin
        c_s.imm = 1'b1; c_s.wb = 1'b1;
        alu_s = int_alu(funct3, (funct3 == 3'b101) && inst[30]);
        case (funct3)
          3'b001:  illegal_s = !shamt_ok(funct7, 1'b0);
          3'b101:  illegal_s = !shamt_ok(funct7, 1'b1);
          default: illegal_s = 1'b0;
        endcase
      end
      OP_IMM32: begin
        c_s.imm = 1'b1; c_s.wb = 1'b1; c_s.op32 = 1'b1;
        alu_s = int_alu(funct3, (funct3 == 3'b101) && inst[30]);
        illegal_s = !(IS64 && ((funct3 == 3'b000)
                    || ((funct3 == 3'b001) && (funct7 == 7'b0000000))
                    || ((funct3 == 3'b101) && ((funct7 == 7'b0000000) || (funct7 == 7'b0100000)))));
      end
      OP: begin
        c_s.wb = 1'b1;
        if (funct7 == 7'b0000001) begin
          c_s.muldiv = 1'b1;
          alu_s      = alu_func_e'({2'b10, funct3});
          illegal_s  = !ENABLE_M;
        end else begin
          alu_s     = int_alu(funct3, funct7[5]);
          illegal_s = !((funct7 == 7'b0000000)
                      || ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
        end
      end
      OP32: begin
        c_s.wb = 1'b1; c_s.op32 = 1'b1;
        if (funct7 == 7'b0000001) begin
          c_s.muldiv = 1'b1;
          alu_s      = alu_func_e'({2'b10, funct3});
          illegal_s  = !(IS64 && ENABLE_M && (funct3 != 3'b001)
                       && (funct3 != 3'b010) && (funct3 != 3'b011));
        end else begin
          alu_s     = int_alu(funct3, funct7[5]);
          illegal_s = !(IS64 && (((funct7 == 7'b0000000)
                      && ((funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b101)))
                      || ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))));
        end
      end
      SYSTEM: begin
        if (funct3 == 3'b000) begin
          ecall_s   = (inst == INST_ECALL);
          ebreak_s  = (inst == INST_EBREAK);
          mret_s    = (inst == INST_MRET);
          illegal_s = !(ecall_s || ebreak_s || mret_s);
        end else if (funct3 == 3'b100) begin
          illegal_s = 1'b1;
        end else begin
          c_s.w_csr = 1'b1; c_s.wb = 1'b1; c_s.imm = funct3[2];
          case (funct3[1:0])
            2'b10:   csr_s = CSR_RS;
            2'b11:   csr_s = CSR_RC;
            default: csr_s = CSR_RW;
          endcase
        end
      end
      default: illegal_s = 1'b1;
    endcase
  end

  // An illegal word carries no side effects downstream, only the trap flag.
  always_comb begin
    if (illegal_s) begin
      ctrl     = '0;
      alu_func = ALU_ADD;
      csr_func = CSR_RW;
      mem_len  = MEM_B;
      trap     = 4'b1000;
    end else begin
      ctrl     = c_s;
      alu_func = alu_s;
      csr_func = csr_s;
      mem_len  = len_s;
      trap     = {1'b0, ecall_s, ebreak_s, mret_s};
    end
  end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered decode stage between fetch and execute: valid/ready handshake,
// flush, and a single pipeline register holding pc plus the decoded bundle.
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b0,
  parameter int PC_W     = XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_alu_func,
  output logic [1:0]      out_csr_func,
  output logic [1:0]      out_mem_len,
  output logic [11:0]     out_ctrl,
  output logic [3:0]      out_trap
);

  ctrl_t      dec_ctrl;
  alu_func_e  dec_alu;
  csr_func_e  dec_csr;
  mem_len_e   dec_len;
  logic [3:0] dec_trap;
  logic       accept;

  rv_decoder #(
    .XLEN     (XLEN),
    .ENABLE_M (ENABLE_M)
  ) u_decoder (
    .inst     (in_inst),
    .ctrl     (dec_ctrl),
    .alu_func (dec_alu),
    .csr_func (dec_csr),
    .mem_len  (dec_len),
    .trap     (dec_trap)
  );

  // Ready while empty or while the held entry drains this cycle, so steady flow has no bubble.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Entry-valid flag: flush wins, a new accept replaces, a lone drain empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Payload register: changes only when a new entry is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pc       <= '0;
      out_alu_func <= 5'd0;
      out_csr_func <= 2'd0;
      out_mem_len  <= 2'd0;
      out_ctrl     <= 12'd0;
      out_trap     <= 4'd0;
    end else if (accept) begin
      out_pc       <= in_pc;
      out_alu_func <= dec_alu;
      out_csr_func <= dec_csr;
      out_mem_len  <= dec_len;
      out_ctrl     <= dec_ctrl;
      out_trap     <= dec_trap;
    end
  end

endmodule
